// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared Ethernet header types and constants for the RX splitter and TX framer
package eth_pkg;

  localparam int ETH_HDR_BYTES = 14;
  localparam logic [47:0] BROADCAST_MAC = 48'hffff_ffff_ffff;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2,
    DROP    = 2'd3
  } eth_rx_state_e;

  // Field order matches wire order, so a byte-wise left shift fills it directly.
  typedef struct packed {
    logic [47:0] dest;
    logic [47:0] src;
    logic [15:0] eth_type;
  } eth_hdr_t;

  function automatic logic mac_pass(input logic [47:0] dest, input logic [47:0] local_mac);
    return (dest == local_mac) || (dest == BROADCAST_MAC);
  endfunction

endpackage

// File: rtl/eth_axis_rx_lite_if.sv
// rtl/eth_axis_rx_lite_if.sv - 8-bit AXI-Stream bundle with master/slave modports
interface eth_axis_rx_lite_if;

  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;
  logic       tuser;

  modport master (output tdata, output tvalid, input tready, output tlast, output tuser);
  modport slave  (input tdata, input tvalid, output tready, input tlast, input tuser);

endinterface

// File: rtl/axis_skid_buf8.sv
// rtl/axis_skid_buf8.sv - 2-entry skid buffer (output register + temp register) with registered ready
module axis_skid_buf8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_tdata,
  input  logic       in_tvalid,
  output logic       in_tready,
  input  logic       in_tlast,
  input  logic       in_tuser,
  output logic [7:0] out_tdata,
  output logic       out_tvalid,
  input  logic       out_tready,
  output logic       out_tlast,
  output logic       out_tuser
);

  logic [9:0] tmp_q;
  logic       tmp_valid;
  logic       ready_early;

  // Ready for next cycle: downstream drains now, or a slot stays free even if a beat lands.
  assign ready_early = out_tready || (!tmp_valid && (!out_tvalid || !in_tvalid));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_tready  <= 1'b0;
      out_tvalid <= 1'b0;
      out_tdata  <= '0;
      out_tlast  <= 1'b0;
      out_tuser  <= 1'b0;
      tmp_valid  <= 1'b0;
      tmp_q      <= '0;
    end else begin
      in_tready <= ready_early;
      if (in_tready) begin
        if (out_tready || !out_tvalid) begin
          out_tvalid                        <= in_tvalid;
          {out_tuser, out_tlast, out_tdata} <= {in_tuser, in_tlast, in_tdata};
        end else begin
          tmp_valid <= in_tvalid;
          tmp_q     <= {in_tuser, in_tlast, in_tdata};
        end
      end else if (out_tready) begin
        out_tvalid                        <= tmp_valid;
        {out_tuser, out_tlast, out_tdata} <= tmp_q;
        tmp_valid                         <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/eth_axis_rx_lite.sv
// rtl/eth_axis_rx_lite.sv - Ethernet RX header splitter; ETH_RX_MAC_FILTER_EN adds a dest MAC filter
// with local_mac input and saturating drop_count output.
module eth_axis_rx_lite
  import eth_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  eth_axis_rx_lite_if.slave   s_axis,
  output logic                m_eth_hdr_valid,
  input  logic                m_eth_hdr_ready,
  output logic [47:0]         m_eth_dest_mac,
  output logic [47:0]         m_eth_src_mac,
  output logic [15:0]         m_eth_type,
  eth_axis_rx_lite_if.master  m_eth_payload_axis,
  output logic                busy,
  output logic                error_header_early_termination
`ifdef ETH_RX_MAC_FILTER_EN
  ,
  input  logic [47:0]         local_mac,
  output logic [15:0]         drop_count
`endif
);

  localparam int HDR_BYTES = ETH_HDR_BYTES;
  localparam logic [3:0] LAST_PTR = 4'(HDR_BYTES - 1);

  if (DATA_WIDTH != 8) begin : g_bad_width
`ifdef TARGET_SIM
    $error("eth_axis_rx_lite supports DATA_WIDTH=8 only");
`endif
  end

  eth_rx_state_e state;
  logic [3:0]    ptr;
  eth_hdr_t      hdr_q;
  eth_hdr_t      hdr_next;
  logic          ready_en;
  logic          rx_ready;
  logic          accept;
  logic          skid_ready;
  logic          skid_valid;
  logic [7:0]    skid_tdata;
  logic          skid_tvalid;
  logic          skid_tlast;
  logic          skid_tuser;

  assign hdr_next = {hdr_q[103:0], s_axis.tdata};
  assign accept   = s_axis.tvalid && rx_ready;
  assign s_axis.tready = rx_ready;

  assign m_eth_dest_mac = hdr_q.dest;
  assign m_eth_src_mac  = hdr_q.src;
  assign m_eth_type     = hdr_q.eth_type;

  // ready_en keeps tready low for the first cycle out of reset.
  always_comb begin
    rx_ready = 1'b0;
    case (state)
      IDLE:    rx_ready = ready_en && !m_eth_hdr_valid;
      HEADER:  rx_ready = 1'b1;
      PAYLOAD: rx_ready = skid_ready;
      DROP:    rx_ready = 1'b1;
      default: rx_ready = 1'b0;
    endcase
  end

  assign skid_valid = s_axis.tvalid && (state == PAYLOAD);

  axis_skid_buf8 u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_tdata   (s_axis.tdata),
    .in_tvalid  (skid_valid),
    .in_tready  (skid_ready),
    .in_tlast   (s_axis.tlast),
    .in_tuser   (s_axis.tuser),
    .out_tdata  (skid_tdata),
    .out_tvalid (skid_tvalid),
    .out_tready (m_eth_payload_axis.tready),
    .out_tlast  (skid_tlast),
    .out_tuser  (skid_tuser)
  );

  assign m_eth_payload_axis.tdata  = skid_tdata;
  assign m_eth_payload_axis.tvalid = skid_tvalid;
  assign m_eth_payload_axis.tlast  = skid_tlast;
  assign m_eth_payload_axis.tuser  = skid_tuser;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                          <= IDLE;
      ptr                            <= '0;
      hdr_q                          <= '0;
      m_eth_hdr_valid                <= 1'b0;
      busy                           <= 1'b0;
      error_header_early_termination <= 1'b0;
      ready_en                       <= 1'b0;
`ifdef ETH_RX_MAC_FILTER_EN
      drop_count                     <= '0;
`endif
    end else begin
      ready_en                       <= 1'b1;
      error_header_early_termination <= 1'b0;
      if (m_eth_hdr_valid && m_eth_hdr_ready) m_eth_hdr_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            hdr_q <= hdr_next;
            if (s_axis.tlast) begin
              error_header_early_termination <= 1'b1;
            end else begin
              ptr   <= 4'd1;
              state <= HEADER;
              busy  <= 1'b1;
            end
          end
        end
        HEADER: begin
          if (accept) begin
            hdr_q <= hdr_next;
            ptr   <= ptr + 4'd1;
            if (s_axis.tlast) begin
              // A header-only frame also lands here: zero-length payload is an error.
              error_header_early_termination <= 1'b1;
              ptr   <= '0;
              state <= IDLE;
              busy  <= 1'b0;
            end else if (ptr == LAST_PTR) begin
              ptr <= '0;
`ifdef ETH_RX_MAC_FILTER_EN
              if (mac_pass(hdr_next.dest, local_mac)) begin
                m_eth_hdr_valid <= 1'b1;
                state           <= PAYLOAD;
              end else begin
                state <= DROP;
                if (drop_count != 16'hffff) drop_count <= drop_count + 16'd1;
              end
`else
              m_eth_hdr_valid <= 1'b1;
              state           <= PAYLOAD;
`endif
            end
          end
        end
        PAYLOAD, DROP: begin
          if (accept && s_axis.tlast) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_axis_rx_lite.sv
// tb/tb_eth_axis_rx_lite.sv - randomized self-checking bench for eth_axis_rx_lite
module tb_eth_axis_rx_lite;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  eth_axis_rx_lite_if s_axis ();
  eth_axis_rx_lite_if m_pl ();

  logic        hdr_valid;
  logic        hdr_ready;
  logic [47:0] dest;
  logic [47:0] src;
  logic [15:0] etype;
  logic        busy;
  logic        err;
`ifdef ETH_RX_MAC_FILTER_EN
  logic [47:0] local_mac = 48'h02_00_00_00_00_01;
  logic [15:0] drop_count;
`endif

  eth_axis_rx_lite dut (
    .clk                            (clk),
    .rst_n                          (rst_n),
    .s_axis                         (s_axis),
    .m_eth_hdr_valid                (hdr_valid),
    .m_eth_hdr_ready                (hdr_ready),
    .m_eth_dest_mac                 (dest),
    .m_eth_src_mac                  (src),
    .m_eth_type                     (etype),
    .m_eth_payload_axis             (m_pl),
    .busy                           (busy),
    .error_header_early_termination (err)
`ifdef ETH_RX_MAC_FILTER_EN
    ,
    .local_mac                      (local_mac),
    .drop_count                     (drop_count)
`endif
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [111:0] exp_hdr[$];
  logic [111:0] got_hdr[$];
  logic [9:0]   exp_pl[$];
  logic [9:0]   got_pl[$];
  int exp_err = 0;
  int got_err = 0;
  int exp_drop = 0;
  bit cur_pass = 1'b0;
  int pl_mode = 0;
  int hdr_mode = 0;

  function automatic bit dest_passes(input logic [47:0] d);
`ifdef ETH_RX_MAC_FILTER_EN
    return (d == local_mac) || (d == 48'hffff_ffff_ffff);
`else
    return (d == d);
`endif
  endfunction

  task automatic model_frame(input logic [7:0] f[$], input bit tuser_last);
    logic [111:0] h = '0;
    cur_pass = 1'b0;
    if (f.size() <= 14) begin
      exp_err++;
      return;
    end
    for (int i = 0; i < 14; i++) h = {h[103:0], f[i]};
    if (!dest_passes(h[111:64])) begin
      exp_drop++;
      return;
    end
    cur_pass = 1'b1;
    exp_hdr.push_back(h);
    for (int i = 14; i < f.size(); i++)
      exp_pl.push_back({tuser_last && (i == f.size() - 1), i == f.size() - 1, f[i]});
  endtask

  task automatic make_frame(output logic [7:0] f[$], input logic [47:0] d, input logic [47:0] s,
                            input logic [15:0] t, input int plen, input bit seq);
    f = {};
    for (int i = 0; i < 6; i++) f.push_back(d[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) f.push_back(s[47-8*i -: 8]);
    f.push_back(t[15:8]);
    f.push_back(t[7:0]);
    for (int i = 0; i < plen; i++) f.push_back(seq ? 8'(i) : 8'($urandom));
  endtask

  task automatic send_frame(input logic [7:0] f[$], input bit tuser_last, input bit gaps, input bit no_last);
    for (int i = 0; i < f.size(); i++) begin
      int cyc = 0;
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_axis.tvalid = 1'b0;
        @(posedge clk); #1;
      end
      s_axis.tvalid = 1'b1;
      s_axis.tdata  = f[i];
      s_axis.tlast  = !no_last && (i == f.size() - 1);
      s_axis.tuser  = tuser_last && s_axis.tlast;
      forever begin
        @(negedge clk);
        if (s_axis.tready) break;
        cyc++;
        if (cyc > 400) begin
          check("s_tready_timeout", 128'(0), 128'(1));
          break;
        end
      end
      @(posedge clk); #1;
    end
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
    s_axis.tuser  = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] f[$], input bit tuser_last, input bit gaps);
    model_frame(f, tuser_last);
    send_frame(f, tuser_last, gaps, 1'b0);
  endtask

  initial begin
    m_pl.tready = 1'b0;
    hdr_ready   = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (pl_mode)
        0:       m_pl.tready = 1'b1;
        1:       m_pl.tready = ~m_pl.tready;
        2:       m_pl.tready = 1'($urandom_range(0, 1));
        default: m_pl.tready = 1'b0;
      endcase
      case (hdr_mode)
        0:       hdr_ready = 1'b1;
        1:       hdr_ready = 1'($urandom_range(0, 1));
        default: hdr_ready = 1'b0;
      endcase
    end
  end

  int           byte_idx = 0;
  bit           lat_pending = 1'b0;
  bit           prev_stall = 1'b0;
  logic [111:0] prev_h = '0;

  // Protocol monitor: captures handshakes and checks timing rules mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      byte_idx    = 0;
      lat_pending = 1'b0;
      prev_stall  = 1'b0;
      got_hdr.delete();
      got_pl.delete();
      got_err     = 0;
    end else begin
      check("busy", 128'(busy), 128'(byte_idx != 0));
      if (lat_pending) check("hdr_latency", 128'(hdr_valid), 128'(1));
      lat_pending = 1'b0;
      if (byte_idx == 0 && hdr_valid) check("hdr_pending_stall", 128'(s_axis.tready), 128'(0));
      if (prev_stall) check("hdr_stable", 128'({hdr_valid, dest, src, etype}), 128'({1'b1, prev_h}));
      prev_stall = hdr_valid && !hdr_ready;
      prev_h     = {dest, src, etype};
      if (hdr_valid && hdr_ready) got_hdr.push_back({dest, src, etype});
      if (m_pl.tvalid && m_pl.tready) got_pl.push_back({m_pl.tuser, m_pl.tlast, m_pl.tdata});
      if (err) got_err++;
      if (s_axis.tvalid && s_axis.tready) begin
        byte_idx++;
        if (byte_idx == 14 && !s_axis.tlast && cur_pass) lat_pending = 1'b1;
        if (s_axis.tlast) byte_idx = 0;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  fa[$];
    logic [7:0]  fb[$];
    logic [7:0]  fr[$];
    logic [47:0] d;
    int          plen;
    int          tot;

    s_axis.tvalid = 1'b0;
    s_axis.tdata  = '0;
    s_axis.tlast  = 1'b0;
    s_axis.tuser  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_tready", 128'(s_axis.tready), 128'(0));
    check("rst_hdr_valid", 128'(hdr_valid), 128'(0));
    check("rst_pl_tvalid", 128'(m_pl.tvalid), 128'(0));
    check("rst_pl_tdata", 128'(m_pl.tdata), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_err", 128'(err), 128'(0));
    check("rst_hdr_fields", 128'({dest, src, etype}), 128'(0));
`ifdef ETH_RX_MAC_FILTER_EN
    check("rst_drop_count", 128'(drop_count), 128'(0));
`endif
    @(posedge clk); #1 rst_n = 1'b1;

    // Mid-frame reset with header pending and payload stalled in the skid.
    hdr_mode = 2;
    pl_mode  = 3;
    make_frame(fr, 48'h02_00_00_00_00_01, 48'h02_00_00_00_00_07, 16'h86dd, 1, 1'b0);
    cur_pass = 1'b1;
    send_frame(fr, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("mid_hdr_valid_set", 128'(hdr_valid), 128'(1));
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_hdr_valid", 128'(hdr_valid), 128'(0));
    check("mid_rst_pl_tvalid", 128'(m_pl.tvalid), 128'(0));
    check("mid_rst_busy", 128'(busy), 128'(0));
    hdr_mode = 0;
    pl_mode  = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    make_frame(fa, 48'h02_00_00_00_00_01, 48'h02_00_00_00_00_02, 16'h0800, 50, 1'b1);
    run_frame(fa, 1'b0, 1'b0);

    pl_mode = 1;
    run_frame(fa, 1'b0, 1'b0);
    pl_mode = 0;

    fr = fa[0:9];
    run_frame(fr, 1'b0, 1'b0);
    run_frame(fa, 1'b0, 1'b0);

    fr = fa[0:13];
    run_frame(fr, 1'b0, 1'b0);

    make_frame(fb, 48'h02_00_00_00_00_01, 48'h02_00_00_00_00_03, 16'h0806, 20, 1'b0);
    hdr_mode = 2;
    run_frame(fa, 1'b0, 1'b0);
    s_axis.tvalid = 1'b1;
    s_axis.tdata  = fb[0];
    repeat (5) @(negedge clk);
    check("b2b_stall_tready", 128'(s_axis.tready), 128'(0));
    check("b2b_hdr_held", 128'(hdr_valid), 128'(1));
    fork
      run_frame(fb, 1'b0, 1'b0);
      begin
        repeat (20) @(posedge clk);
        #1 hdr_mode = 0;
      end
    join

    run_frame(fb, 1'b1, 1'b0);

`ifdef ETH_RX_MAC_FILTER_EN
    make_frame(fr, 48'h02_00_00_00_00_09, 48'h02_00_00_00_00_02, 16'h0800, 10, 1'b1);
    run_frame(fr, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("drop_count_one", 128'(drop_count), 128'(exp_drop));
    make_frame(fr, 48'hffff_ffff_ffff, 48'h02_00_00_00_00_05, 16'h0800, 8, 1'b1);
    run_frame(fr, 1'b0, 1'b0);
`endif

    for (int n = 0; n < 40; n++) begin
      pl_mode  = $urandom_range(0, 2);
      hdr_mode = $urandom_range(0, 1);
      d = {16'($urandom), 32'($urandom)};
`ifdef ETH_RX_MAC_FILTER_EN
      case ($urandom_range(0, 2))
        0:       d = local_mac;
        1:       d = 48'hffff_ffff_ffff;
        default: d = {16'($urandom), 32'($urandom)};
      endcase
`endif
      plen = $urandom_range(1, 26);
      make_frame(fr, d, {16'($urandom), 32'($urandom)}, 16'($urandom), plen, 1'b0);
      if ($urandom_range(0, 4) == 0) begin
        tot = $urandom_range(1, 14);
        while (fr.size() > tot) void'(fr.pop_back());
      end
      run_frame(fr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    pl_mode  = 0;
    hdr_mode = 0;
    repeat (100) @(posedge clk);
    @(negedge clk);

    check("hdr_count", 128'(got_hdr.size()), 128'(exp_hdr.size()));
    for (int i = 0; i < got_hdr.size() && i < exp_hdr.size(); i++)
      check($sformatf("hdr_%0d", i), 128'(got_hdr[i]), 128'(exp_hdr[i]));
    check("payload_count", 128'(got_pl.size()), 128'(exp_pl.size()));
    for (int i = 0; i < got_pl.size() && i < exp_pl.size(); i++)
      check($sformatf("payload_%0d", i), 128'(got_pl[i]), 128'(exp_pl[i]));
    check("early_term_pulses", 128'(got_err), 128'(exp_err));
`ifdef ETH_RX_MAC_FILTER_EN
    check("drop_count_final", 128'(drop_count), 128'(exp_drop));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
